// File: rtl/sd_fifo_tail_mc.sv
// Multi-channel FIFO tail: N logical FIFOs read from one shared single-port
// memory, one read per cycle granted round-robin, each channel with its own
// wrapping region, 2-entry output buffer and optional commit/abort pointers.
module sd_fifo_tail_mc #(
  parameter int width    = 8,
  parameter int depth    = 64,
  parameter int channels = 4,
  parameter int commit   = 0,
  parameter int asz      = $clog2(depth),
  parameter int csz      = $clog2(channels)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [channels*asz-1:0]     bound_low,
  input  logic [channels*asz-1:0]     bound_high,
  input  logic [channels*asz-1:0]     wrptr,
  output logic [channels*asz-1:0]     cur_rdptr,
  output logic [channels*asz-1:0]     com_rdptr,
  output logic [channels*(asz+1)-1:0] usage,
  output logic                        mem_re,
  output logic [asz-1:0]              mem_addr,
  input  logic [width-1:0]            mem_rd_data,
  output logic [channels-1:0]         p_srdy,
  input  logic [channels-1:0]         p_drdy,
  input  logic [channels-1:0]         p_commit,
  input  logic [channels-1:0]         p_abort,
  output logic [channels*width-1:0]   p_data
);

  logic [asz-1:0]   lo [channels];
  logic [asz-1:0]   hi [channels];
  logic [asz-1:0]   wp [channels];
  logic [asz-1:0]   cur [channels];
  logic [asz-1:0]   com [channels];
  logic [asz-1:0]   pop_ptr [channels];
  logic [asz-1:0]   cur_nxt [channels];
  logic [asz-1:0]   pop_nxt [channels];
  logic [1:0]       cnt [channels];
  logic [2:0]       occ [channels];
  logic             rd_idx [channels];
  logic             wr_idx [channels];
  logic [width-1:0] bdata [channels][2];

  logic [channels-1:0] xfer, abort, elig, inflight, bwr;
  logic                rvalid, found;
  logic [csz-1:0]      rchan, gptr, gsel, gnext;
  int unsigned         idx;

  function automatic logic [asz-1:0] ptr_p1(input logic [asz-1:0] p,
                                            input logic [asz-1:0] lo_v,
                                            input logic [asz-1:0] hi_v);
    return (p == hi_v) ? lo_v : p + 1'b1;
  endfunction

  // Per-channel unpacking, eligibility and output packing
  always_comb begin
    for (int unsigned c = 0; c < channels; c++) begin
      lo[c]       = bound_low[c*asz +: asz];
      hi[c]       = bound_high[c*asz +: asz];
      wp[c]       = wrptr[c*asz +: asz];
      cur_nxt[c]  = ptr_p1(cur[c], lo[c], hi[c]);
      pop_nxt[c]  = ptr_p1(pop_ptr[c], lo[c], hi[c]);
      abort[c]    = (commit != 0) && p_abort[c];
      xfer[c]     = (cnt[c] != 2'd0) && p_drdy[c];
      inflight[c] = rvalid && (rchan == c[csz-1:0]);
      bwr[c]      = inflight[c] && !abort[c];
      // occupancy once the in-flight read lands, net of this cycle's pop
      occ[c]      = {1'b0, cnt[c]} + {2'b00, inflight[c]} - {2'b00, xfer[c]};
      elig[c]     = enable && (wp[c] != cur[c]) && !abort[c] && (occ[c] < 3'd2);
      cur_rdptr[c*asz +: asz] = cur[c];
      com_rdptr[c*asz +: asz] = (commit != 0) ? com[c] : cur[c];
      p_srdy[c]   = (cnt[c] != 2'd0);
      p_data[c*width +: width] = bdata[c][rd_idx[c]];
      if (wp[c] >= cur[c])
        usage[c*(asz+1) +: asz+1] = {1'b0, wp[c]} - {1'b0, cur[c]};
      else
        usage[c*(asz+1) +: asz+1] = ({1'b0, hi[c]} - {1'b0, lo[c]} + 1'b1)
                                    - ({1'b0, cur[c]} - {1'b0, wp[c]});
    end
  end

  // Round-robin arbiter: search starts at gptr, first eligible channel wins
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < channels; i++) begin
      idx = (32'(gptr) + i) % channels;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gsel  = idx[csz-1:0];
      end
    end
    gnext    = (int'(gsel) == channels - 1) ? '0 : gsel + 1'b1;
    mem_re   = found && !reset;
    mem_addr = mem_re ? cur[gsel] : '0;
  end

  // Pointer, buffer-control and read-tracking state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < channels; c++) begin
        cur[c]     <= lo[c];
        com[c]     <= lo[c];
        pop_ptr[c] <= lo[c];
        cnt[c]     <= '0;
        rd_idx[c]  <= 1'b0;
        wr_idx[c]  <= 1'b0;
      end
      rvalid <= 1'b0;
      rchan  <= '0;
      gptr   <= '0;
    end else begin
      rvalid <= mem_re;
      rchan  <= gsel;
      if (mem_re) gptr <= gnext;
      for (int unsigned c = 0; c < channels; c++) begin
        if (abort[c]) begin
          cur[c]     <= com[c];
          pop_ptr[c] <= com[c];
          cnt[c]     <= '0;
          rd_idx[c]  <= 1'b0;
          wr_idx[c]  <= 1'b0;
        end else begin
          if (mem_re && (gsel == c[csz-1:0])) cur[c] <= cur_nxt[c];
          if (xfer[c]) begin
            pop_ptr[c] <= pop_nxt[c];
            rd_idx[c]  <= ~rd_idx[c];
          end
          if (bwr[c]) wr_idx[c] <= ~wr_idx[c];
          cnt[c] <= cnt[c] + {1'b0, bwr[c]} - {1'b0, xfer[c]};
          // commit captures the pop pointer after this cycle's transfer
          if ((commit != 0) && p_commit[c])
            com[c] <= xfer[c] ? pop_nxt[c] : pop_ptr[c];
        end
      end
    end
  end

  // Output buffer storage, written when a read returns
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < channels; c++) begin
      if (bwr[c]) bdata[c][wr_idx[c]] <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_sd_fifo_tail_mc.sv
// Directed bench for sd_fifo_tail_mc: one commit=1 instance and one commit=0
// instance share stimulus; each has a behavioural memory returning 0x80+addr.
module tb_sd_fifo_tail_mc;
  logic        clk = 1'b0;
  logic        reset, enable;
  logic [23:0] bound_low, bound_high, wrptr;
  logic [3:0]  p_drdy, p_commit, p_abort;

  logic [23:0] cur1, com1, cur0, com0;
  logic [27:0] use1, use0;
  logic        re1, re0;
  logic [5:0]  addr1, addr0;
  logic [7:0]  rd1, rd0;
  logic [3:0]  srdy1, srdy0;
  logic [31:0] data1, data0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sd_fifo_tail_mc #(.width(8), .depth(64), .channels(4), .commit(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .bound_low(bound_low), .bound_high(bound_high), .wrptr(wrptr),
    .cur_rdptr(cur1), .com_rdptr(com1), .usage(use1),
    .mem_re(re1), .mem_addr(addr1), .mem_rd_data(rd1),
    .p_srdy(srdy1), .p_drdy(p_drdy), .p_commit(p_commit), .p_abort(p_abort),
    .p_data(data1));

  sd_fifo_tail_mc #(.width(8), .depth(64), .channels(4), .commit(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .bound_low(bound_low), .bound_high(bound_high), .wrptr(wrptr),
    .cur_rdptr(cur0), .com_rdptr(com0), .usage(use0),
    .mem_re(re0), .mem_addr(addr0), .mem_rd_data(rd0),
    .p_srdy(srdy0), .p_drdy(p_drdy), .p_commit(p_commit), .p_abort(p_abort),
    .p_data(data0));

  // memories with one-cycle read latency
  always @(posedge clk) begin
    if (re1) rd1 <= 8'h80 + {2'b00, addr1};
    if (re0) rd0 <= 8'h80 + {2'b00, addr0};
  end

  function automatic logic [5:0] f6(input logic [23:0] v, input int c);
    return v[c*6 +: 6];
  endfunction
  function automatic logic [6:0] f7(input logic [27:0] v, input int c);
    return v[c*7 +: 7];
  endfunction
  function automatic logic [7:0] f8(input logic [31:0] v, input int c);
    return v[c*8 +: 8];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wp(input int c, input logic [5:0] v);
    wrptr[c*6 +: 6] = v;
  endtask

  task automatic default_bounds;
    for (int c = 0; c < 4; c++) begin
      bound_low[c*6 +: 6]  = 6'(16 * c);
      bound_high[c*6 +: 6] = 6'(16 * c + 15);
    end
  endtask

  // reset with default bounds, all channels empty; returns just after release
  task automatic do_reset;
    default_bounds();
    wrptr    = bound_low;
    p_drdy   = 4'hF;
    p_commit = 4'h0;
    p_abort  = 4'h0;
    #1;
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
  endtask

  int t4 [13] = '{0, 16, 1, 17, 2, 3, 4, 5, 6, 7, 8, 9, -1};
  int t3 [6]  = '{16, 32, 48, 1, 17, 33};
  logic [3:0] s3 [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [6:0] exp_rd;

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    p_drdy   = 4'hF;
    p_commit = 4'h0;
    p_abort  = 4'h0;
    default_bounds();
    wrptr = bound_low;
    #2;
    // reset state
    check("rst_cur", cur1, {6'd48, 6'd32, 6'd16, 6'd0});
    check("rst_com", com1, {6'd48, 6'd32, 6'd16, 6'd0});
    check("rst_srdy", srdy1, 4'h0);
    check("rst_usage", use1, 28'h0);
    set_wp(0, 6'd5);
    #1;
    check("rst_mem_re_forced", re1, 1'b0);
    set_wp(0, 6'd0);
    tick();
    reset = 1'b0;
    #1;
    check("idle_mem_re", re1, 1'b0);

    // 1: three entries on channel 0
    tick();
    set_wp(0, 6'd3);
    #1;
    check("t1_w0_rd", {re1, addr1}, {1'b1, 6'd0});
    check("t1_w0_usage", f7(use1, 0), 7'd3);
    tick();
    check("t1_w1_cur", f6(cur1, 0), 6'd1);
    check("t1_w1_rd", {re1, addr1}, {1'b1, 6'd1});
    check("t1_w1_usage", f7(use1, 0), 7'd2);
    check("t1_w1_srdy", srdy1[0], 1'b0);
    tick();
    check("t1_w2_srdy", srdy1[0], 1'b1);
    check("t1_w2_data", f8(data1, 0), 8'h80);
    check("t1_w2_usage", f7(use1, 0), 7'd1);
    check("t1_w2_rd", {re1, addr1}, {1'b1, 6'd2});
    tick();
    check("t1_w3_data", f8(data1, 0), 8'h81);
    check("t1_w3_rd", {re1, addr1}, 7'h00);
    check("t1_w3_usage", f7(use1, 0), 7'd0);
    tick();
    check("t1_w4_data", f8(data1, 0), 8'h82);
    tick();
    check("t1_w5_srdy", srdy1[0], 1'b0);
    check("t1_com_tracks_cur", f6(com0, 0), 6'd3);
    check("t1_com_held", f6(com1, 0), 6'd0);

    // 2: wrap inside region 8..11
    bound_low[5:0]  = 6'd8;
    bound_high[5:0] = 6'd11;
    set_wp(0, 6'd8);
    #1;
    reset = 1'b1;
    #1;
    check("t2_rst_cur", f6(cur1, 0), 6'd8);
    tick();
    reset = 1'b0;
    set_wp(0, 6'd11);
    #1;
    check("t2_w0_rd", {re1, addr1}, {1'b1, 6'd8});
    tick();
    tick();
    tick();
    check("t2_w3_cur", f6(cur1, 0), 6'd11);
    check("t2_w3_rd", {re1, addr1}, 7'h00);
    check("t2_w3_data", f8(data1, 0), 8'h89);
    tick();
    check("t2_w4_data", f8(data1, 0), 8'h8A);
    tick();
    check("t2_w5_srdy", srdy1[0], 1'b0);
    set_wp(0, 6'd9);
    #1;
    check("t2_w5_usage", f7(use1, 0), 7'd2);
    check("t2_w5_rd", {re1, addr1}, {1'b1, 6'd11});
    tick();
    check("t2_w6_cur", f6(cur1, 0), 6'd8);
    check("t2_w6_rd", {re1, addr1}, {1'b1, 6'd8});
    tick();
    check("t2_w7_cur", f6(cur1, 0), 6'd9);
    check("t2_w7_rd", {re1, addr1}, 7'h00);
    check("t2_w7_data", f8(data1, 0), 8'h8B);
    tick();
    check("t2_w8_data", f8(data1, 0), 8'h88);
    tick();
    check("t2_w9_srdy", srdy1[0], 1'b0);

    // 3: all channels busy, round-robin order
    do_reset();
    for (int c = 0; c < 4; c++) set_wp(c, 6'(16 * c + 8));
    #1;
    check("t3_w0_rd", {re1, addr1}, {1'b1, 6'd0});
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t3_w%0d_rd", i + 1), {re1, addr1}, {1'b1, 6'(t3[i])});
      check($sformatf("t3_w%0d_srdy", i + 1), srdy1, s3[i]);
      if (i == 1) check("t3_w2_data0", f8(data1, 0), 8'h80);
      if (i == 2) check("t3_w3_data1", f8(data1, 1), 8'h90);
    end

    // 4: channel 1 stalled, channel 0 keeps streaming
    do_reset();
    p_drdy = 4'b1101;
    set_wp(0, 6'd10);
    set_wp(1, 6'd26);
    #1;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) tick();
      exp_rd = (t4[i] < 0) ? 7'h00 : {1'b1, 6'(t4[i])};
      check($sformatf("t4_w%0d_rd", i), {re1, addr1}, exp_rd);
      if (i == 7) check("t4_w7_data0", f8(data1, 0), 8'h83);
    end
    check("t4_w12_data0", f8(data1, 0), 8'h88);
    check("t4_w12_srdy1", srdy1[1], 1'b1);
    check("t4_w12_data1", f8(data1, 1), 8'h90);
    check("t4_w12_usage1", f7(use1, 1), 7'd8);
    check("t4_w12_cur1", f6(cur1, 1), 6'd18);
    p_drdy = 4'hF;
    #1;
    check("t4_w12_rd_resume", {re1, addr1}, {1'b1, 6'd18});
    tick();
    check("t4_w13_data1", f8(data1, 1), 8'h91);
    check("t4_w13_data0", f8(data1, 0), 8'h89);

    // 5: commit then abort on channel 2
    do_reset();
    p_drdy = 4'b1011;
    set_wp(2, 6'd40);
    #1;
    tick();
    tick();
    tick();
    check("t5_w3_data", f8(data1, 2), 8'hA0);
    check("t5_w3_cur", f6(cur1, 2), 6'd34);
    p_drdy = 4'hF;
    #1;
    check("t5_w3_rd", {re1, addr1}, {1'b1, 6'd34});
    tick();
    check("t5_w4_data", f8(data1, 2), 8'hA1);
    tick();
    check("t5_w5_data", f8(data1, 2), 8'hA2);
    tick();
    p_drdy   = 4'b1011;
    p_commit = 4'b0100;
    #1;
    check("t5_w6_rd", re1, 1'b0);
    tick();
    p_commit = 4'b0000;
    p_drdy   = 4'hF;
    #1;
    check("t5_w7_com", f6(com1, 2), 6'd35);
    check("t5_w7_data", f8(data1, 2), 8'hA3);
    tick();
    check("t5_w8_data", f8(data1, 2), 8'hA4);
    check("t5_w8_cur", f6(cur1, 2), 6'd38);
    tick();
    p_drdy  = 4'b1011;
    p_abort = 4'b0100;
    #1;
    check("t5_w9_rd", re1, 1'b0);
    check("t5_w9_com", f6(com1, 2), 6'd35);
    tick();
    p_abort = 4'b0000;
    #1;
    check("t5_w10_cur", f6(cur1, 2), 6'd35);
    check("t5_w10_com", f6(com1, 2), 6'd35);
    check("t5_w10_srdy", srdy1[2], 1'b0);
    check("t5_w10_rd", {re1, addr1}, {1'b1, 6'd35});
    check("t5_w10_nocommit_com", f6(com0, 2), 6'd39);
    check("t5_w10_nocommit_data", f8(data0, 2), 8'hA5);
    tick();
    check("t5_w11_rd", {re1, addr1}, {1'b1, 6'd36});
    check("t5_w11_srdy", srdy1[2], 1'b0);

    // 6: reset with a read in flight
    reset = 1'b1;
    #1;
    check("t6_srdy", srdy1, 4'h0);
    check("t6_mem_re", re1, 1'b0);
    check("t6_cur", cur1, {6'd48, 6'd32, 6'd16, 6'd0});
    check("t6_com", com1, {6'd48, 6'd32, 6'd16, 6'd0});
    check("t6_srdy_nocommit", srdy0, 4'h0);
    wrptr = bound_low;
    tick();
    reset = 1'b0;
    #1;
    tick();
    check("t6_post_srdy", srdy1, 4'h0);
    check("t6_post_mem_re", re1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
